// File: rtl/alu_pkg.sv
// Shared operator encodings, FSM states and operator-legality helper for alu_seq_core.
// Divide counts as a legal operator only when ALU_SEQ_DIV_EN is defined.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b000001;
    localparam logic [5:0] OP_SUB = 6'b000010;
    localparam logic [5:0] OP_MUL = 6'b000100;
    localparam logic [5:0] OP_DIV = 6'b001000;
    localparam logic [5:0] OP_AND = 6'b010000;
    localparam logic [5:0] OP_OR  = 6'b100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic isLegalOp(input logic [5:0] op);
        logic w_legal;
        w_legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
                  (op == OP_AND) || (op == OP_OR);
`ifdef ALU_SEQ_DIV_EN
        w_legal = w_legal || (op == OP_DIV);
`endif
        return w_legal;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// A start pulse loads the operands; exactly WIDTH steps follow, and the result then holds until the next start.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
`ifdef ALU_SEQ_DIV_EN
    input  logic               i_isDiv,
`endif
    input  logic [WIDTH-1:0]   i_opA,
    input  logic [WIDTH-1:0]   i_opB,
    output logic               o_lastStep,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    assign o_lastStep = (r_count == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_count  <= COUNT_INIT;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_opA};
            r_mplier <= i_opB;
        end else if (r_count != '0) begin
            r_count  <= r_count - CW'(1);
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    logic               r_isDiv;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     w_shift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diffLow;

    // A zero divisor always fits, which yields an all-ones quotient and leaves the dividend as remainder.
    assign w_shift   = {r_rem, r_quot[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, r_divisor});
    assign w_diffLow = w_shift[WIDTH-1:0] - r_divisor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isDiv   <= 1'b0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_isDiv   <= i_isDiv;
            r_rem     <= '0;
            r_quot    <= i_opA;
            r_divisor <= i_opB;
        end else if (r_count != '0) begin
            if (w_fits) begin
                r_rem  <= w_diffLow;
                r_quot <= {r_quot[WIDTH-2:0], 1'b1};
            end else begin
                r_rem  <= w_shift[WIDTH-1:0];
                r_quot <= {r_quot[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_result = r_isDiv ? {r_rem, r_quot} : r_acc;
`else
    assign o_result = r_acc;
`endif

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked calculator ALU: single-cycle add/sub/and/or plus iterative mul/div, with compare flags.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise divide is rejected as an illegal operator.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   number1,
    input  logic [WIDTH-1:0]   number2,
    input  logic [5:0]         operator_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] output_num,
    output logic               equalityBit,
    output logic               balanceBit,
    output logic               error
);

    alu_state_e         r_state;
    alu_state_e         w_nextState;
    logic [2*WIDTH-1:0] r_result;
    logic               r_useIter;
    logic               r_equal;
    logic               r_balance;
    logic               r_error;

    logic               w_accept;
    logic               w_legal;
    logic               w_isIterOp;
    logic               w_divByZero;
    logic               w_startIter;
    logic               w_iterLast;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_oneCycleResult;
    logic [2*WIDTH-1:0] w_iterResult;

    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;
    assign w_legal  = isLegalOp(operator_mode);

`ifdef ALU_SEQ_DIV_EN
    assign w_isIterOp  = (operator_mode == OP_MUL) || (operator_mode == OP_DIV);
    assign w_divByZero = (operator_mode == OP_DIV) && (number2 == '0);
`else
    assign w_isIterOp  = (operator_mode == OP_MUL);
    assign w_divByZero = 1'b0;
`endif

    assign w_startIter = w_accept && !mode && w_isIterOp;
    assign w_sum       = {1'b0, number1} + {1'b0, number2};
    assign w_diff      = {1'b0, number1} - {1'b0, number2};

    always_comb begin
        w_oneCycleResult = '0;
        if (!mode) begin
            case (operator_mode)
                OP_ADD:  w_oneCycleResult = {{(WIDTH-1){1'b0}}, w_sum};
                OP_SUB:  w_oneCycleResult = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
                OP_AND:  w_oneCycleResult = {{WIDTH{1'b0}}, number1 & number2};
                OP_OR:   w_oneCycleResult = {{WIDTH{1'b0}}, number1 | number2};
                default: w_oneCycleResult = '0;
            endcase
        end
    end

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk        (Clk),
        .rst        (reset),
        .i_start    (w_startIter),
`ifdef ALU_SEQ_DIV_EN
        .i_isDiv    (operator_mode == OP_DIV),
`endif
        .i_opA      (number1),
        .i_opB      (number2),
        .o_lastStep (w_iterLast),
        .o_result   (w_iterResult)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept)   w_nextState = w_startIter ? CALC : DONE;
            CALC: if (w_iterLast) w_nextState = DONE;
            DONE: if (out_ready)  w_nextState = IDLE;
            default:              w_nextState = IDLE;
        endcase
    end

    // Everything except the iterative result is decided at acceptance and held until the next one.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_useIter <= 1'b0;
            r_equal   <= 1'b0;
            r_balance <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_accept) begin
            r_result  <= w_oneCycleResult;
            r_useIter <= w_startIter;
            r_equal   <= (number1 == number2);
            r_balance <= (number1 >= number2);
            r_error   <= !mode && (!w_legal || w_divByZero);
        end
    end

    assign out_valid   = (r_state == DONE);
    assign output_num  = r_useIter ? w_iterResult : r_result;
    assign equalityBit = r_equal;
    assign balanceBit  = r_balance;
    assign error       = r_error;

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed transactions scored against an arithmetic model.
// Follows ALU_SEQ_DIV_EN so the divide expectations match whichever build is compiled.
module tb_alu_seq_core;

    localparam int W = 5;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    localparam logic [5:0] T_ADD = 6'b000001;
    localparam logic [5:0] T_SUB = 6'b000010;
    localparam logic [5:0] T_MUL = 6'b000100;
    localparam logic [5:0] T_DIV = 6'b001000;
    localparam logic [5:0] T_AND = 6'b010000;
    localparam logic [5:0] T_OR  = 6'b100000;

    logic           Clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           mode;
    logic [W-1:0]   number1;
    logic [W-1:0]   number2;
    logic [5:0]     operator_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] output_num;
    logic           equalityBit;
    logic           balanceBit;
    logic           error;

    alu_seq_core #(.WIDTH(W)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode          (mode),
        .number1       (number1),
        .number2       (number2),
        .operator_mode (operator_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .output_num    (output_num),
        .equalityBit   (equalityBit),
        .balanceBit    (balanceBit),
        .error         (error)
    );

    always #5 Clk = ~Clk;

    int cycle = 0;
    always @(posedge Clk) cycle++;

    typedef struct {
        logic [2*W-1:0] res;
        logic           eq;
        logic           bal;
        logic           err;
        int             lat;
        int             acc;
    } exp_t;

    exp_t           expQ[$];
    exp_t           curExp;
    int             testsRun = 0;
    int             testsFailed = 0;
    bit             frontChecked = 0;
    logic [2*W-1:0] heldResult;
    logic [2:0]     heldFlags;
    logic [2*W-1:0] lastResult = '0;
    logic           lastEq = 0;
    logic           lastBal = 0;
    logic           lastErr = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // What the ALU must answer, straight from the arithmetic definition of each operator.
    function automatic exp_t modelOp(input int a, input int b, input logic [5:0] op, input logic m, input int acc);
        exp_t e;
        int   full;
        full  = 1 << (2 * W);
        e.eq  = (a == b);
        e.bal = (a >= b);
        e.res = '0;
        e.err = 1'b0;
        e.lat = 1;
        e.acc = acc;
        if (m) return e;
        if ($countones(op) != 1 || (op == T_DIV && !DIV_ON)) begin
            e.err = 1'b1;
            return e;
        end
        case (op)
            T_ADD: e.res = (2*W)'(a + b);
            T_SUB: e.res = (2*W)'((a - b) & (full - 1));
            T_MUL: begin
                e.res = (2*W)'(a * b);
                e.lat = 1 + W;
            end
            T_DIV: begin
                e.lat = 1 + W;
                if (b == 0) begin
                    e.res = (2*W)'((a << W) | ((1 << W) - 1));
                    e.err = 1'b1;
                end else begin
                    e.res = (2*W)'(((a % b) << W) | (a / b));
                end
            end
            T_AND: e.res = (2*W)'(a & b);
            T_OR:  e.res = (2*W)'(a | b);
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Drive one request, hold it until accepted, and queue the model's answer.
    task automatic applyStimulus(input int a, input int b, input logic [5:0] op, input logic m, output int acc);
        int waitCnt;
        waitCnt = 0;
        @(posedge Clk); #1;
        in_valid      = 1'b1;
        number1       = W'(a);
        number2       = W'(b);
        operator_mode = op;
        mode          = m;
        while (!in_ready && waitCnt < 200) begin
            @(posedge Clk); #1;
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle;
        expQ.push_back(modelOp(a, b, op, m, acc));
        @(posedge Clk); #1;
        in_valid      = 1'b0;
        number1       = W'($urandom);
        number2       = W'($urandom);
        operator_mode = 6'($urandom);
        mode          = 1'($urandom);
    endtask

    task automatic waitDone();
        int waitCnt;
        waitCnt = 0;
        while (expQ.size() != 0 && waitCnt < 100) begin
            @(posedge Clk); #1;
            waitCnt++;
        end
        if (expQ.size() != 0) begin
            checkOutput("done_timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    // Scoreboard: first valid cycle checks latency and values, later cycles check the hold.
    always @(negedge Clk) begin
        if (reset) begin
            frontChecked = 0;
        end else if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                curExp = expQ[0];
                if (!frontChecked) begin
                    checkOutput("latency", cycle - curExp.acc, curExp.lat);
                    checkOutput("output_num", output_num, curExp.res);
                    checkOutput("equalityBit", equalityBit, curExp.eq);
                    checkOutput("balanceBit", balanceBit, curExp.bal);
                    checkOutput("error", error, curExp.err);
                    heldResult   = output_num;
                    heldFlags    = {equalityBit, balanceBit, error};
                    frontChecked = 1;
                end else begin
                    checkOutput("hold_output_num", output_num, heldResult);
                    checkOutput("hold_flags", {equalityBit, balanceBit, error}, heldFlags);
                end
                if (out_ready) begin
                    lastResult   = output_num;
                    lastEq       = equalityBit;
                    lastBal      = balanceBit;
                    lastErr      = error;
                    frontChecked = 0;
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc1;
        int acc2;
        reset         = 1'b1;
        in_valid      = 1'b0;
        mode          = 1'b0;
        number1       = '0;
        number2       = '0;
        operator_mode = '0;
        out_ready     = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_output_num", output_num, 0);
        checkOutput("rst_flags", {equalityBit, balanceBit, error}, 3'b000);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        applyStimulus(8, 7, T_ADD, 1'b0, acc1);
        waitDone();
        checkOutput("add_8_7", lastResult, 15);
        checkOutput("add_flags", {lastEq, lastBal, lastErr}, 3'b010);

        applyStimulus(7, 8, T_SUB, 1'b0, acc1);
        waitDone();
        checkOutput("sub_7_8", lastResult, 10'h3FF);
        checkOutput("sub_balance", lastBal, 0);

        applyStimulus(6, 6, T_MUL, 1'b1, acc1);
        waitDone();
        checkOutput("cmp_6_6", lastResult, 0);
        checkOutput("cmp_flags", {lastEq, lastBal, lastErr}, 3'b110);

        applyStimulus(31, 31, T_MUL, 1'b0, acc1);
        for (int k = 0; k < 6; k++) begin
            checkOutput("mul_in_ready_low", in_ready, 0);
            @(posedge Clk); #1;
        end
        waitDone();
        checkOutput("mul_31_31", lastResult, 10'h3C1);

        applyStimulus(29, 4, T_DIV, 1'b0, acc1);
        waitDone();
        if (DIV_ON) begin
            checkOutput("div_29_4", lastResult, 10'h027);
            checkOutput("div_29_4_err", lastErr, 0);
        end else begin
            checkOutput("div_off_29_4", lastResult, 0);
            checkOutput("div_off_29_4_err", lastErr, 1);
        end

        applyStimulus(9, 0, T_DIV, 1'b0, acc1);
        waitDone();
        if (DIV_ON) checkOutput("div_9_0", lastResult, 10'h13F);
        else        checkOutput("div_off_9_0", lastResult, 0);
        checkOutput("div_9_0_err", lastErr, 1);

        out_ready = 1'b0;
        applyStimulus(5, 3, 6'b000011, 1'b0, acc1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
            @(posedge Clk); #1;
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        checkOutput("stall_released_valid", out_valid, 0);
        waitDone();
        checkOutput("illegal_op", lastResult, 0);
        checkOutput("illegal_err", lastErr, 1);

        applyStimulus(3, 5, T_OR, 1'b0, acc1);
        applyStimulus(12, 10, T_AND, 1'b0, acc2);
        waitDone();
        checkOutput("b2b_spacing", acc2 - acc1, 2);
        checkOutput("and_12_10", lastResult, 8);

        applyStimulus(13, 11, T_MUL, 1'b0, acc1);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_output_num", output_num, 0);
        checkOutput("midrst_flags", {equalityBit, balanceBit, error}, 3'b000);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(posedge Clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        applyStimulus(1, 1, T_ADD, 1'b0, acc1);
        waitDone();
        checkOutput("after_rst_add", lastResult, 2);

        repeat (2) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the 5-bit `Main` calculator ALU. It accepts two WIDTH-bit unsigned operands and a one-hot operator, and returns a 2·WIDTH-bit result with equality and balance (compare) flags. Add, subtract and logic operations complete in one cycle. Multiply and divide are iterative, taking WIDTH cycles each. The block sits between the operand-entry front end and the display/result register stage, and uses valid/ready on both sides.

## Interface
- WIDTH, 5, operand width in bits (≥2); result width is 2·WIDTH
- Clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/operator presented
- in_ready  out  1  block can accept (high only in IDLE)
- mode  in  1  0 = compute, 1 = compare-only
- number1  in  WIDTH  operand A (unsigned)
- number2  in  WIDTH  operand B (unsigned)
- operator_mode  in  6  one-hot: 000001 add, 000010 sub, 000100 mul, 001000 div, 010000 AND, 100000 OR
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- output_num  out  2·WIDTH  result
- equalityBit  out  1  number1 == number2
- balanceBit  out  1  number1 ≥ number2
- error  out  1  illegal operator or divide by zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid, operands and operator are captured.
  - Single-cycle ops, compare-only mode, and illegal operators go to DONE.
  - mul and div go to CALC with an iteration counter of WIDTH.
- CALC: one shift-add (mul) or restoring-subtract (div) step per cycle. The counter decrements each step. At 0 the state goes to DONE.
- DONE: out_valid=1; outputs are held stable. When out_ready=1 the state returns to IDLE in the next cycle, and out_valid drops.
- Result rules:
  - add: zero-extended WIDTH+1-bit sum.
  - sub: WIDTH+1-bit two's-complement difference, sign-extended to 2·WIDTH.
  - mul: full 2·WIDTH product.
  - div: {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
  - AND/OR: zero-extended.
- mode=1: output_num=0, error=0, flags only; operator_mode is ignored.
- Illegal operator (not exactly one bit set, mode=0): output_num=0, error=1.
- Divide by zero: quotient is all ones, remainder = number1, error=1. Still takes the full WIDTH cycles.
- Flags are computed from the captured operands in every mode and valid alongside out_valid.
- Reset values: in_ready=0 during reset, and 1 from the first cycle after release. out_valid=0, output_num=0, equalityBit=0, balanceBit=0, error=0, state IDLE.
- Reset mid-operation (CALC or DONE): the operation is abandoned, all outputs go to reset values, and no result is produced.

## Timing
- Acceptance is a cycle where in_valid && in_ready.
- If acceptance is in cycle N:
  - Single-cycle ops, compare and illegal operators: out_valid in cycle N+1.
  - mul/div: out_valid in cycle N+1+WIDTH.
- Back-to-back throughput, single-cycle ops: one result per 2 cycles with out_ready tied high.
- in_ready is low in CALC and DONE; input changes there are ignored.
- out_ready may be high before out_valid. Completion is out_valid && out_ready in the same cycle.

## Configuration
- ALU_SEQ_DIV_EN defined: the divider datapath is present and div behaves as above.
- Undefined: operator 001000 is treated as illegal (1-cycle, output 0, error=1), and no divider logic is synthesised.

## Structure
- Shared package alu_pkg:
  - The six one-hot operator constants.
  - The state enum (IDLE/CALC/DONE).
  - A helper returning whether an operator is legal.
- One sub-module, alu_iter_unit: the shared multi-cycle shift register/accumulator for mul and div. It has start/done, a WIDTH-cycle counter, and the divider branch under ALU_SEQ_DIV_EN.
- Handshake, FSM, single-cycle ops and flags live in alu_seq_core.

## Test plan
- WIDTH=5, add 8+7 → out_valid at N+1, output_num=15, equalityBit=0, balanceBit=1, error=0.
- sub 7−8 → output_num=10'h3FF, balanceBit=0. Compare mode=1, 6 vs 6 → output_num=0, equalityBit=1, balanceBit=1.
- mul 31×31 → out_valid exactly at N+6, output_num=961 (10'h3C1). in_ready stays low N+1..N+6.
- div 29/4 → output_num=10'h027 (rem 1, quot 7). div 9/0 → 10'h13F with error=1. Without ALU_SEQ_DIV_EN, div → output_num=0, error=1 at N+1.
- operator_mode=000011 → output_num=0, error=1 at N+1. out_ready held low 3 cycles → outputs stable and in_ready low, then completion at the first out_ready high.
- Assert reset at cycle N+3 of a mul → all outputs 0 immediately, no out_valid. The next transaction, add 1+1, yields 2 normally.
